// File: rtl/snn_pkg.sv
// Shared types and widths for the snn_core round-robin scheduler.
//   sched_state_t : scheduler FSM states
//   DIGIT_W       : width of a classified digit
//   NO_DIGIT      : digit code reported on a watchdog abort
//   WDOG_W        : width of the RUN-phase watchdog counter
//   IDX_W         : width of a bank index (supports up to 16 banks)
package snn_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        START   = 2'd1,
        RUN     = 2'd2,
        CAPTURE = 2'd3
    } sched_state_t;

    localparam int unsigned DIGIT_W = 4;
    localparam int unsigned WDOG_W  = 16;
    localparam int unsigned IDX_W   = 4;

    localparam logic [DIGIT_W-1:0] NO_DIGIT = 4'hF;

endpackage

// File: rtl/snn_sched_if.sv
// Bundle of every signal between the scheduler, the sample-RAM array and snn_core.
//   master : environment side (banks + core) driving requests, RAM data, core status
//   slave  : scheduler side driving acks, RAM address, core control and results
interface snn_sched_if import snn_pkg::*; #(
    parameter int unsigned N_BANKS = 10,
    parameter int unsigned ADDR_W  = 10
) ();

    logic [N_BANKS-1:0] req;
    logic [N_BANKS-1:0] ack;
    logic [ADDR_W-1:0]  bank_addr;
    logic [N_BANKS-1:0] bank_q;
    logic               core_start;
    logic               core_done;
    logic [ADDR_W-1:0]  core_addr;
    logic               core_q;
    logic [DIGIT_W-1:0] core_digit;
    logic               res_valid;
    logic [IDX_W-1:0]   res_bank;
    logic [DIGIT_W-1:0] res_digit;
    logic               res_timeout;
    logic               busy;

    modport master (
        output req, bank_q, core_done, core_addr, core_digit,
        input  ack, bank_addr, core_start, core_q,
               res_valid, res_bank, res_digit, res_timeout, busy
    );

    modport slave (
        input  req, bank_q, core_done, core_addr, core_digit,
        output ack, bank_addr, core_start, core_q,
               res_valid, res_bank, res_digit, res_timeout, busy
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: lowest requesting index at or after ptr, wrapping.
//   req       : per-requester request vector
//   ptr       : index with highest priority this round (must be < N)
//   gnt_idx   : chosen index (0 when nothing requests)
//   gnt_valid : at least one request present
module rr_arbiter import snn_pkg::*; #(
    parameter int unsigned N = 10
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid
);

    logic [N-1:0] req_rot;
    int unsigned  sum;

    // Rotate so bit k corresponds to index (ptr + k) mod N.
    assign req_rot = N'({req, req} >> ptr);

    // First set bit of the rotated vector, mapped back to an absolute index.
    always_comb begin
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        sum       = 0;
        for (int k = 0; k < int'(N); k++) begin
            if (!gnt_valid && req_rot[k]) begin
                gnt_valid = 1'b1;
                sum       = 32'(ptr) + 32'(k);
                if (sum >= N) begin
                    sum = sum - N;
                end
                gnt_idx = IDX_W'(sum);
            end
        end
    end

endmodule

// File: rtl/snn_sched.sv
// Round-robin scheduler sharing one snn_core among N_BANKS 1-bit sample RAMs.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : snn_sched_if slave port
//     req/ack              : per-bank request, one-cycle completion pulse
//     bank_addr/bank_q     : address broadcast to banks, per-bank read data
//     core_start/core_done : core start pulse, core completion
//     core_addr/core_q     : core input address, steered bank data
//     core_digit           : core classification result
//     res_*                : result strobe, bank tag, digit, watchdog-abort flag
//     busy                 : scheduler not idle
module snn_sched import snn_pkg::*; #(
    parameter int unsigned N_BANKS = 10,
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned TIMEOUT = 65535
) (
    input  logic      clk,
    input  logic      rst,
    snn_sched_if.slave bus
);

    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT - 1);

    sched_state_t      state_q;
    sched_state_t      state_d;
    logic [IDX_W-1:0]  grant_q;
    logic [IDX_W-1:0]  grant_d;
    logic [IDX_W-1:0]  rr_ptr_q;
    logic [WDOG_W-1:0] wdog_q;
    logic [IDX_W-1:0]  arb_idx;
    logic              arb_valid;
    logic              timeout_c;
    logic [ADDR_W-1:0] addr_c;

    rr_arbiter #(.N(N_BANKS)) u_arb (
        .req       (bus.req),
        .ptr       (rr_ptr_q),
        .gnt_idx   (arb_idx),
        .gnt_valid (arb_valid)
    );

    // The core addresses all banks at once; only the granted bank's bit reaches it.
    assign addr_c        = bus.core_addr;
    assign bus.bank_addr = addr_c;
    assign bus.core_q    = |(bus.bank_q & (N_BANKS'(1) << grant_q));

    // Next-state logic; done is checked before the watchdog so it wins a tie.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        timeout_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    grant_d = arb_idx;
                    state_d = START;
                end
            end
            START: state_d = RUN;
            RUN: begin
                if (bus.core_done) begin
                    state_d = CAPTURE;
                end else if (wdog_q == WDOG_LAST) begin
                    state_d   = CAPTURE;
                    timeout_c = 1'b1;
                end
            end
            CAPTURE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, grant, watchdog and round-robin pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
            wdog_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            if (state_q == START) begin
                wdog_q <= '0;
            end else if (state_q == RUN) begin
                wdog_q <= wdog_q + WDOG_W'(1);
            end
            if (state_q == CAPTURE) begin
                rr_ptr_q <= (grant_q == IDX_W'(N_BANKS - 1)) ? '0 : grant_q + IDX_W'(1);
            end
        end
    end

    // Registered outputs decoded from the next state; results latch on RUN exit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.core_start  <= 1'b0;
            bus.ack         <= '0;
            bus.res_valid   <= 1'b0;
            bus.busy        <= 1'b0;
            bus.res_bank    <= '0;
            bus.res_digit   <= '0;
            bus.res_timeout <= 1'b0;
        end else begin
            bus.core_start <= (state_d == START);
            bus.ack        <= (state_d == CAPTURE) ? (N_BANKS'(1) << grant_d) : '0;
            bus.res_valid  <= (state_d == CAPTURE);
            bus.busy       <= (state_d != IDLE);
            if (state_q == RUN && state_d == CAPTURE) begin
                bus.res_bank    <= grant_q;
                bus.res_timeout <= timeout_c;
                bus.res_digit   <= timeout_c ? NO_DIGIT : bus.core_digit;
            end
        end
    end

endmodule
